// File: rtl/muxn_rr.sv
// N-channel registered mux with fixed-select and round-robin grant modes.
// Define MUXN_RR_PARITY_EN to add the registered even-parity output out_par.
module muxn_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
`ifdef MUXN_RR_PARITY_EN
    ,
    output logic                      out_par
`endif
);

    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    ptr_nxt;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    gnt_data;
    logic [CHANNELS-1:0] grant;
    logic                gnt_any;
    logic                load_en;

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (load_en && !rst) ? grant : '0;

    always_comb begin
        int c;
        c        = 0;
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        ptr_nxt  = rr_ptr;
        if (!mode) begin
            // comparing against each in-range index keeps an oversized sel from granting
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_data = in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                c = (int'(rr_ptr) + k) % CHANNELS;
                if (!gnt_any && in_valid[c]) begin
                    grant[c] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SEL_W'(c);
                    gnt_data = in_data[c*WIDTH +: WIDTH];
                    ptr_nxt  = (c == CHANNELS - 1) ? '0 : SEL_W'(c + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
`ifdef MUXN_RR_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (load_en) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= gnt_data;
                out_ch   <= gnt_idx;
`ifdef MUXN_RR_PARITY_EN
                out_par  <= ^gnt_data;
`endif
                if (mode) begin
                    rr_ptr <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_muxn_rr.sv
// Randomized scoreboard bench for muxn_rr (CHANNELS=4, WIDTH=8, SEL_W=3).
module tb_muxn_rr;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 3;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] ch;
    } word_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_ready = 1'b0;
`ifdef MUXN_RR_PARITY_EN
    logic            out_par;
`endif

    logic [W-1:0] d [CH];
    word_t        q[$];
    logic [SW-1:0] seen[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  m_ov = 1'b0;
    int  m_ptr = 0;

    always #5 clk = ~clk;
    assign in_data = {d[3], d[2], d[1], d[0]};

    muxn_rr #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
`ifdef MUXN_RR_PARITY_EN
        , .out_par(out_par)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = valid channel at the smallest rotational distance from ptr.
    function automatic int pick(bit m, int s, logic [CH-1:0] v, int ptr);
        int best = -1;
        int bd = CH;
        if (!m) return (s < CH && v[s]) ? s : -1;
        for (int c = 0; c < CH; c++) begin
            if (v[c] && ((c - ptr + CH) % CH) < bd) begin
                bd = (c - ptr + CH) % CH;
                best = c;
            end
        end
        return best;
    endfunction

    task automatic tick();
        int g;
        bit le;
        logic [CH-1:0] exp_ir;
        word_t w;
        #1;
        g = rst ? -1 : pick(mode, int'(sel), in_valid, m_ptr);
        le = !m_ov || out_ready;
        exp_ir = (g >= 0 && le) ? CH'(1 << g) : '0;
        chk("in_ready", in_ready, exp_ir);
        if (g >= 0) begin
            w.data = d[g];
            w.ch = SW'(g);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ov = 1'b0;
            m_ptr = 0;
            q.delete();
        end else if (le) begin
            if (g >= 0) begin
                m_ov = 1'b1;
                q.push_back(w);
                if (mode) m_ptr = (g + 1) % CH;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic chk_seen(input string name, input int exp[$]);
        chk({name, "_len"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk(name, seen[i], exp[i]);
    endtask

    // Monitor: the head of the queue is the word the DUT must be showing.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", out_valid, q.size() != 0);
                if (out_valid && q.size() > 0) begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_ch", out_ch, q[0].ch);
`ifdef MUXN_RR_PARITY_EN
                    chk("out_par", out_par, ^q[0].data);
`endif
                    if (out_ready) begin
                        seen.push_back(out_ch);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < CH; i++) d[i] = W'(8'h10 * (i + 1));
        @(posedge clk);
        #1;
        // reset with everything valid
        rst = 1'b1; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        seen.delete();
        // round-robin, all valid
        for (int i = 0; i < 6; i++) tick();
        // reset mid-operation with rr_ptr at 2
        rst = 1'b1; in_valid = '0;
        tick();
        chk_seen("rr_all", '{0, 1, 2, 3, 0, 1});
        chk("rst_mid_valid", out_valid, 1'b0);
        rst = 1'b0;
        seen.delete();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) tick();
        in_valid = '0;
        tick();
        chk_seen("rr_13", '{1, 3, 1, 3});
        // fixed select
        mode = 1'b0; sel = 3'd2; d[2] = 8'hA5; in_valid = '1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fix_ready", in_ready, 4'b0100);
            tick();
            chk("fix_data", out_data, 8'hA5);
            chk("fix_ch", out_ch, 2);
        end
        sel = 3'd5;
        #1 chk("oor_ready", in_ready, 0);
        tick();
        chk("oor_valid", out_valid, 1'b0);
        // back-pressure
        sel = 3'd0; d[0] = 8'h11;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = 1'($urandom);
            sel = SW'($urandom);
            in_valid = CH'($urandom);
            d[1] = W'($urandom); d[2] = W'($urandom); d[3] = W'($urandom);
            #1 chk("bp_ready", in_ready, 0);
            tick();
            chk("bp_data", out_data, 8'h11);
            chk("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1; mode = 1'b0; sel = 3'd2; in_valid = 4'b0100;
        d[2] = 8'h3C;
        #1 chk("bp_refill_ready", in_ready, 4'b0100);
        tick();
        chk("bp_refill_data", out_data, 8'h3C);
        // parity words
        sel = 3'd0; in_valid = 4'b0001; d[0] = 8'hA5;
        tick();
`ifdef MUXN_RR_PARITY_EN
        chk("par_a5", out_par, 1'b0);
`endif
        d[0] = 8'h07;
        tick();
`ifdef MUXN_RR_PARITY_EN
        chk("par_07", out_par, 1'b1);
`endif
        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            mode = 1'($urandom);
            sel = SW'($urandom);
            in_valid = CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < CH; i++) d[i] = W'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
